// File: rtl/multiport_mem_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multiport_mem_if
// Brief    : Write/read/clear bus of the multiport register-file memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface multiport_mem_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                clr_req;
    logic                busy;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DW/8-1:0]     wbe;
    logic [DW-1:0]       din;
    logic                wr_drop;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*DW-1:0]   rdata;

    modport master (
        output clr_req, we, waddr, wbe, din, raddr,
        input  busy, wr_drop, rdata
    );

    modport slave (
        input  clr_req, we, waddr, wbe, din, raddr,
        output busy, wr_drop, rdata
    );
endinterface
`default_nettype wire

// File: rtl/multiport_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multiport_mem
// Brief    : Register file, one byte-enabled write port, NRD read ports,
//            registered or combinational reads, built-in clear sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module multiport_mem #(
    parameter int DW       = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int READ_REG = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    multiport_mem_if.slave      bus
);
    localparam int              c_NB    = DW / 8;
    localparam logic [AW:0]     c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   c_LAST  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            wr_drop_q, wr_drop_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];

    logic            w_busy;
    logic            w_waddr_ok;
    logic            w_wr_ok;

    assign w_busy      = reset | (state_q == S_CLEAR);
    assign w_waddr_ok  = ({1'b0, bus.waddr} < c_DEPTH);
    assign w_wr_ok     = bus.we & ~w_busy & w_waddr_ok;
    assign bus.busy    = w_busy;
    assign bus.wr_drop = wr_drop_q;

    // Clear and write never coincide: a write is only accepted when not busy.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_d     = mem_q;
        wr_drop_d = bus.we & (w_busy | ~w_waddr_ok);

        unique case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (!reset) begin
                    mem_d[clr_cnt_q] = '0;
                end
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == c_LAST) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end
            end
        endcase

        if (w_wr_ok) begin
            for (int b = 0; b < c_NB; b++) begin
                if (bus.wbe[b]) begin
                    mem_d[bus.waddr][8*b +: 8] = bus.din[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Array contents are left alone by reset; the clear sequence zeroes them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_ra_ok;

        assign w_ra    = bus.raddr[k*AW +: AW];
        assign w_ra_ok = ({1'b0, w_ra} < c_DEPTH);

        if (READ_REG != 0) begin : g_reg
            logic [DW-1:0] rdata_q, rdata_d;

            // Sampling mem_d gives write-first behaviour on a same-edge hit.
            always_comb begin
                rdata_d = (w_busy || !w_ra_ok) ? '0 : mem_d[w_ra];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign bus.rdata[k*DW +: DW] = rdata_q;
        end else begin : g_comb
            assign bus.rdata[k*DW +: DW] = (w_busy || !w_ra_ok) ? '0 : mem_q[w_ra];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multiport_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_multiport_mem
// Brief    : Self-checking bench: registered 8x16 NRD=3 instance and
//            combinational 6x16 NRD=2 instance against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_multiport_mem;
    localparam int c_DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        we, clr_req;
    logic [2:0]  waddr;
    logic [1:0]  wbe;
    logic [15:0] din;
    logic [2:0]  ra [3];

    multiport_mem_if #(.DW(16), .DEPTH(8), .NRD(3)) ifa ();
    multiport_mem_if #(.DW(16), .DEPTH(6), .NRD(2)) ifb ();

    assign ifa.we = we;  assign ifa.clr_req = clr_req; assign ifa.waddr = waddr;
    assign ifa.wbe = wbe; assign ifa.din = din;
    assign ifa.raddr = {ra[2], ra[1], ra[0]};
    assign ifb.we = we;  assign ifb.clr_req = clr_req; assign ifb.waddr = waddr;
    assign ifb.wbe = wbe; assign ifb.din = din;
    assign ifb.raddr = {ra[1], ra[0]};

    multiport_mem #(.DW(16), .DEPTH(8), .NRD(3), .READ_REG(1)) u_dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    multiport_mem #(.DW(16), .DEPTH(6), .NRD(2), .READ_REG(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    // Model: index 0 = 8-entry registered instance, 1 = 6-entry combinational.
    logic [15:0] mm [2][8];
    int          clr_left [2];
    int          clr_idx  [2];
    bit          drop     [2];
    logic [15:0] rq_a     [3];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_upd(input int d, input int depth, output bit busy_pre);
        busy_pre = reset || (clr_left[d] > 0);
        if (reset) begin
            clr_left[d] = depth;
            clr_idx[d]  = 0;
            drop[d]     = 1'b0;
        end else begin
            drop[d] = we && (busy_pre || int'(waddr) >= depth);
            if (busy_pre) begin
                mm[d][clr_idx[d]] = '0;
                clr_idx[d]++;
                clr_left[d]--;
            end else begin
                if (we && int'(waddr) < depth)
                    for (int b = 0; b < 2; b++)
                        if (wbe[b]) mm[d][waddr][8*b +: 8] = din[8*b +: 8];
                if (clr_req) begin
                    clr_left[d] = depth;
                    clr_idx[d]  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] e;
        chk("busyA", ifa.busy, reset || clr_left[0] > 0);
        chk("dropA", ifa.wr_drop, drop[0]);
        for (int k = 0; k < 3; k++) chk($sformatf("rdA%0d", k), ifa.rdata[k*c_DW +: c_DW], rq_a[k]);
        chk("busyB", ifb.busy, reset || clr_left[1] > 0);
        chk("dropB", ifb.wr_drop, drop[1]);
        for (int k = 0; k < 2; k++) begin
            e = (reset || clr_left[1] > 0 || int'(ra[k]) >= 6) ? 16'h0 : mm[1][ra[k]];
            chk($sformatf("rdB%0d", k), ifb.rdata[k*c_DW +: c_DW], e);
        end
    endtask

    task automatic cycle();
        bit bp;
        @(posedge clk);
        model_upd(0, 8, bp);
        for (int k = 0; k < 3; k++) rq_a[k] = (bp || int'(ra[k]) >= 8) ? 16'h0 : mm[0][ra[k]];
        model_upd(1, 6, bp);
        @(negedge clk);
        check_all();
    endtask

    task automatic count_busy(input string tag, input int exp_n);
        int n = 0;
        while (ifa.busy && n < 20) begin
            cycle();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic set_ra(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        ra[0] = a0; ra[1] = a1; ra[2] = a2;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; clr_req = 1'b0; waddr = '0; wbe = '0; din = '0;
        set_ra(0, 0, 0);

        // 1: reset, then exactly 8 busy cycles, all reads zero
        cycle(); cycle();
        reset = 1'b0;
        count_busy("busy_len_after_reset", 8);
        for (int i = 0; i < 8; i++) begin
            set_ra(3'(i), 3'(i), 3'(i));
            cycle();
            chk("read_zero", ifa.rdata[15:0], 16'h0);
        end

        // 2: byte-enable merge
        we = 1'b1; waddr = 3; wbe = 2'b11; din = 16'hBEEF; cycle();
        wbe = 2'b01; din = 16'h1234; cycle();
        we = 1'b0; set_ra(3, 3, 3); cycle();
        chk("merge_A", ifa.rdata[15:0], 16'hBE34);
        chk("merge_B", ifb.rdata[15:0], 16'hBE34);

        // wbe=0 write: no change, no drop
        we = 1'b1; wbe = 2'b00; din = 16'hFFFF; cycle();
        we = 1'b0; cycle();
        chk("wbe0_keep", ifa.rdata[15:0], 16'hBE34);

        // 3: registered write-first read
        we = 1'b1; waddr = 5; wbe = 2'b11; din = 16'hA5A5; set_ra(5, 5, 5); cycle();
        chk("write_first", ifa.rdata[15:0], 16'hA5A5);
        we = 1'b0;

        // 4: out-of-range write on the 6-entry instance, then write while busy
        we = 1'b1; waddr = 7; din = 16'hFFFF; set_ra(7, 5, 7); cycle();
        chk("drop_oor_B", ifb.wr_drop, 1'b1);
        chk("nodrop_A", ifa.wr_drop, 1'b0);
        we = 1'b0; cycle();
        chk("drop_pulse_end", ifb.wr_drop, 1'b0);
        clr_req = 1'b1; cycle();
        clr_req = 1'b0; we = 1'b1; waddr = 2; din = 16'h5555; cycle();
        chk("drop_busy_A", ifa.wr_drop, 1'b1);
        we = 1'b0;
        count_busy("busy_len_clr_req", 7);

        // 5: fill, clear, reset at clear cycle 4, restart
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wbe = 2'b11; din = 16'($urandom); cycle();
        end
        we = 1'b0; clr_req = 1'b1; cycle();
        clr_req = 1'b0; cycle(); cycle(); cycle();
        reset = 1'b1; cycle();
        reset = 1'b0;
        count_busy("busy_len_restart", 8);
        for (int i = 0; i < 8; i++) begin
            set_ra(3'(i), 3'(i), 3'(i)); cycle();
            chk("cleared", ifa.rdata[47:0], 48'h0);
        end

        // 6: independent ports, two on addr 0, one on addr 7 being written
        we = 1'b1; waddr = 0; wbe = 2'b11; din = 16'h1111; cycle();
        waddr = 7; din = 16'h7777; set_ra(0, 0, 7); cycle();
        chk("ind_p0", ifa.rdata[15:0],  16'h1111);
        chk("ind_p1", ifa.rdata[31:16], 16'h1111);
        chk("ind_p2", ifa.rdata[47:32], 16'h7777);
        we = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            we      = 1'($urandom);
            waddr   = 3'($urandom);
            wbe     = 2'($urandom);
            din     = 16'($urandom);
            set_ra(3'($urandom), 3'($urandom), 3'($urandom));
            clr_req = ($urandom_range(0, 31) == 0);
            reset   = ($urandom_range(0, 127) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
